posterize_roi: RTL and testbench
================================

POSTERIZE_ROI -- requirements
Module: posterize_roi

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of colour channels.
REQ-002 SHALL have parameter CH_DEPTH, default 8, bits per channel.
REQ-003 SHALL have parameter TRIM_W, default 4, width of each per-channel trim field.
REQ-004 SHALL have parameters HS_POL and VS_POL, default "NEGATIVE", sync active polarity ("NEGATIVE"/"POSITIVE").
REQ-005 SHALL have parameters X_CNT_W, default 12, and Y_CNT_W, default 11, for pixel/line counter widths.
REQ-006 SHALL have i_pclk  input  1  pixel clock, all logic on its rising edge.
REQ-007 SHALL have i_arst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have i_en  input  1  posterize enable, shadowed per frame.
REQ-009 SHALL have i_round_en  input  1  1 = round-to-nearest, 0 = truncate, shadowed.
REQ-010 SHALL have i_trim  input  NUM_CH*TRIM_W  LSBs to clear per channel, channel 0 in LSBs, shadowed.
REQ-011 SHALL have i_x_start, i_x_end  input  X_CNT_W each  ROI columns [start,end), shadowed.
REQ-012 SHALL have i_y_start, i_y_end  input  Y_CNT_W each  ROI lines [start,end), shadowed.
REQ-013 SHALL have i_vsync, i_hsync, i_de  input  1 each  video timing.
REQ-014 SHALL have i_data  input  NUM_CH*CH_DEPTH  pixel, channel 0 in LSBs.
REQ-015 SHALL have o_vsync, o_hsync, o_de  output  1 each  timing delayed 2 cycles.
REQ-016 SHALL have o_data  output  NUM_CH*CH_DEPTH  processed pixel.
REQ-017 SHALL have o_in_roi  output  1  high when o_data pixel was posterized.
REQ-018 SHALL have o_cfg_upd  output  1  one-cycle pulse when shadow config loads.

Function
REQ-019 Shadow config SHALL load from all shadowed inputs on the cycle i_vsync goes inactive->active; o_cfg_upd SHALL pulse high the following cycle.
REQ-020 Shadowed-input changes between vsync edges SHALL have no effect on o_data or o_in_roi.
REQ-021 X counter SHALL clear while i_hsync is active, increment on each i_de=1 cycle, and saturate at all-ones; current pixel column = value before increment.
REQ-022 Y counter SHALL clear while i_vsync is active, increment on each i_de 1->0 transition, and saturate at all-ones.
REQ-023 In-ROI SHALL be i_de & shadow_en & x_start<=x<x_end & y_start<=y<y_end; start>=end SHALL yield an empty ROI.
REQ-024 Pipeline SHALL be 2 stages: stage 1 registers timing, data, and the ROI flag; stage 2 applies posterization. Latency SHALL be exactly 2 cycles for every output except o_cfg_upd.
REQ-025 Per channel with t = min(trim, CH_DEPTH): truncate mode SHALL clear the low t bits.
REQ-026 Round mode SHALL add 2^(t-1) before clearing; on overflow it SHALL saturate to (2^CH_DEPTH-1) with the low t bits cleared; t=CH_DEPTH SHALL yield 0.
REQ-027 t=0 SHALL pass the channel unchanged in both modes.
REQ-028 Pixels not in ROI, including blanking, SHALL pass unchanged with o_in_roi=0.
REQ-029 Channels SHALL be independent; no carry SHALL cross channel boundaries.

Reset
REQ-030 On i_arst, o_data, o_de, o_in_roi, o_cfg_upd, counters, and pipeline registers SHALL be 0; o_vsync/o_hsync SHALL be their inactive level per VS_POL/HS_POL.
REQ-031 On i_arst, shadow config SHALL be en=0, round=0, trim=0, window=0 (empty ROI), so the block is pass-through until the first vsync after reset.
REQ-032 Reset asserted mid-line SHALL take effect immediately; no partial pixel SHALL emerge after release.

Verification
REQ-033 Trunc, trim ch0=5, ROI covers frame, i_data ch0=0xB7 -> o_data ch0=0xA0 two cycles later, o_in_roi=1.
REQ-034 Round, trim=5: 0xB7 -> 0xC0; 0xF7 -> 0xE0 (saturated); trim=8: 0x80 -> 0x00.
REQ-035 ROI x=[4,8), y=[0,1): line 0 columns 3 and 8 unchanged, columns 4-7 posterized; line 1 entirely unchanged.
REQ-036 Change trim 5->2 mid-frame -> output still uses 5 until next vsync edge, then o_cfg_upd pulses once and trim 2 applies.
REQ-037 x_start=10, x_end=10 -> no pixel modified, o_in_roi never 1.
REQ-038 Assert i_arst mid-line -> all outputs reset values the same cycle; after release, pass-through until a vsync edge loads config.

Source files
------------

// File: rtl/posterize_roi.sv
// Region-of-interest posterizer: per-channel LSB trim (truncate or round) on a
// 2-stage video pipeline, with frame-shadowed configuration loaded at vsync.

module posterize_ch #(
  parameter int CH_DEPTH = 8,
  parameter int TRIM_W   = 4
) (
  input  logic [CH_DEPTH-1:0] din,
  input  logic [TRIM_W-1:0]   trim,
  input  logic                round_en,
  output logic [CH_DEPTH-1:0] dout
);
  logic [CH_DEPTH-1:0] mask;
  logic [CH_DEPTH:0]   half;
  logic [CH_DEPTH:0]   sum;
  int                  t;

  always_comb begin
    t = (int'(trim) > CH_DEPTH) ? CH_DEPTH : int'(trim);
    for (int b = 0; b < CH_DEPTH; b++) begin
      mask[b] = (b >= t);
      half[b] = (b == t - 1);
    end
    half[CH_DEPTH] = 1'b0;
    sum = {1'b0, din} + half;
    // carry out of the rounded sum clamps to the largest representable level
    if (t == 0)             dout = din;
    else if (!round_en)     dout = din & mask;
    else if (sum[CH_DEPTH]) dout = mask;
    else                    dout = sum[CH_DEPTH-1:0] & mask;
  end
endmodule

module posterize_roi #(
  parameter int    NUM_CH   = 3,
  parameter int    CH_DEPTH = 8,
  parameter int    TRIM_W   = 4,
  parameter string HS_POL   = "NEGATIVE",
  parameter string VS_POL   = "NEGATIVE",
  parameter int    X_CNT_W  = 12,
  parameter int    Y_CNT_W  = 11
) (
  input  logic                       i_pclk,
  input  logic                       i_arst,
  input  logic                       i_en,
  input  logic                       i_round_en,
  input  logic [NUM_CH*TRIM_W-1:0]   i_trim,
  input  logic [X_CNT_W-1:0]         i_x_start,
  input  logic [X_CNT_W-1:0]         i_x_end,
  input  logic [Y_CNT_W-1:0]         i_y_start,
  input  logic [Y_CNT_W-1:0]         i_y_end,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_de,
  input  logic [NUM_CH*CH_DEPTH-1:0] i_data,
  output logic                       o_vsync,
  output logic                       o_hsync,
  output logic                       o_de,
  output logic [NUM_CH*CH_DEPTH-1:0] o_data,
  output logic                       o_in_roi,
  output logic                       o_cfg_upd
);
  localparam logic VS_IDLE = (VS_POL == "POSITIVE") ? 1'b0 : 1'b1;
  localparam logic HS_IDLE = (HS_POL == "POSITIVE") ? 1'b0 : 1'b1;

  typedef struct packed {
    logic                     en;
    logic                     rnd;
    logic [NUM_CH*TRIM_W-1:0] trim;
    logic [X_CNT_W-1:0]       xs;
    logic [X_CNT_W-1:0]       xe;
    logic [Y_CNT_W-1:0]       ys;
    logic [Y_CNT_W-1:0]       ye;
  } cfg_t;

  cfg_t               cfg_in, shd;
  logic               vs_act, hs_act, vs_act_q, vs_rise, de_q, in_roi;
  logic [X_CNT_W-1:0] x;
  logic [Y_CNT_W-1:0] y;

  assign cfg_in  = {i_en, i_round_en, i_trim, i_x_start, i_x_end, i_y_start, i_y_end};
  assign vs_act  = i_vsync ^ VS_IDLE;
  assign hs_act  = i_hsync ^ HS_IDLE;
  assign vs_rise = vs_act & ~vs_act_q;
  assign in_roi  = i_de & shd.en & (x >= shd.xs) & (x < shd.xe) & (y >= shd.ys) & (y < shd.ye);

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      vs_act_q  <= 1'b0;
      de_q      <= 1'b0;
      shd       <= '0;
      o_cfg_upd <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      vs_act_q  <= vs_act;
      de_q      <= i_de;
      o_cfg_upd <= vs_rise;
      if (vs_rise) shd <= cfg_in;
      if (hs_act)                 x <= '0;
      else if (i_de && x != '1)   x <= x + 1'b1;
      // line count advances at the end of each active run
      if (vs_act)                         y <= '0;
      else if (de_q && !i_de && y != '1)  y <= y + 1'b1;
    end
  end

  // stage 1 carries its own copy of trim/round so a config load cannot split a pixel
  logic                       s1_vs, s1_hs, s1_de, s1_roi, s1_rnd;
  logic [NUM_CH*TRIM_W-1:0]   s1_trim;
  logic [NUM_CH*CH_DEPTH-1:0] s1_data;
  logic [NUM_CH-1:0][CH_DEPTH-1:0] post;

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      s1_vs   <= VS_IDLE;
      s1_hs   <= HS_IDLE;
      s1_de   <= 1'b0;
      s1_roi  <= 1'b0;
      s1_rnd  <= 1'b0;
      s1_trim <= '0;
      s1_data <= '0;
    end else begin
      s1_vs   <= i_vsync;
      s1_hs   <= i_hsync;
      s1_de   <= i_de;
      s1_roi  <= in_roi;
      s1_rnd  <= shd.rnd;
      s1_trim <= shd.trim;
      s1_data <= i_data;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    posterize_ch #(.CH_DEPTH(CH_DEPTH), .TRIM_W(TRIM_W)) u_ch (
      .din      (s1_data[c*CH_DEPTH +: CH_DEPTH]),
      .trim     (s1_trim[c*TRIM_W +: TRIM_W]),
      .round_en (s1_rnd),
      .dout     (post[c])
    );
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      o_vsync  <= VS_IDLE;
      o_hsync  <= HS_IDLE;
      o_de     <= 1'b0;
      o_in_roi <= 1'b0;
      o_data   <= '0;
    end else begin
      o_vsync  <= s1_vs;
      o_hsync  <= s1_hs;
      o_de     <= s1_de;
      o_in_roi <= s1_roi;
      o_data   <= s1_roi ? post : s1_data;
    end
  end
endmodule

// File: tb/tb_posterize_roi.sv
// Randomized scoreboard bench for posterize_roi: driver pushes expected pixels
// from an arithmetic reference model, monitor pops and compares on o_de.

module tb_posterize_roi;
  typedef struct packed {
    logic        en;
    logic        rnd;
    logic [11:0] trim;
    logic [11:0] xs;
    logic [11:0] xe;
    logic [10:0] ys;
    logic [10:0] ye;
  } cfg_t;

  logic        pclk = 1'b0;
  logic        arst = 1'b0;
  logic        vsync = 1'b1, hsync = 1'b1, de = 1'b0;
  logic [23:0] data = '0;
  cfg_t        cur = '0, shd = '0, nxt = '0;
  logic        o_vsync, o_hsync, o_de, o_in_roi, o_cfg_upd;
  logic [23:0] o_data;

  int n_cmp = 0, n_err = 0;
  bit mon_on = 1'b0;
  logic [23:0] pix_q[$];
  logic [24:0] exp_q[$];

  always #5 pclk = ~pclk;

  posterize_roi #(
    .NUM_CH(3), .CH_DEPTH(8), .TRIM_W(4), .HS_POL("NEGATIVE"), .VS_POL("NEGATIVE"),
    .X_CNT_W(12), .Y_CNT_W(11)
  ) dut (
    .i_pclk(pclk), .i_arst(arst), .i_en(cur.en), .i_round_en(cur.rnd), .i_trim(cur.trim),
    .i_x_start(cur.xs), .i_x_end(cur.xe), .i_y_start(cur.ys), .i_y_end(cur.ye),
    .i_vsync(vsync), .i_hsync(hsync), .i_de(de), .i_data(data),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
    .o_in_roi(o_in_roi), .o_cfg_upd(o_cfg_upd)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Posterize reference: quantise each channel to a multiple of 2^t.
  function automatic logic [23:0] model_px(logic [23:0] d, cfg_t c);
    logic [23:0] r;
    r = d;
    for (int ch = 0; ch < 3; ch++) begin
      int v, t, q, o;
      v = int'(d[ch*8 +: 8]);
      t = int'(c.trim[ch*4 +: 4]);
      if (t > 8) t = 8;
      q = 1 << t;
      if (c.rnd) begin
        o = ((v + q / 2) / q) * q;
        if (o > 255) o = (255 / q) * q;
      end else o = (v / q) * q;
      r[ch*8 +: 8] = 8'(o);
    end
    return r;
  endfunction

  function automatic cfg_t mk_cfg(bit en, bit rnd, logic [11:0] trim, int xs, int xe, int ys, int ye);
    cfg_t c;
    c.en = en; c.rnd = rnd; c.trim = trim;
    c.xs = 12'(xs); c.xe = 12'(xe); c.ys = 11'(ys); c.ye = 11'(ye);
    return c;
  endfunction

  // Expected timing: what the DUT sampled two edges ago
  logic [2:0] h0 = 3'b110, h1 = 3'b110;
  logic       vprev = 1'b0, upd_e = 1'b0;
  always @(posedge pclk or posedge arst) begin
    if (arst) begin
      h0 <= 3'b110; h1 <= 3'b110; vprev <= 1'b0; upd_e <= 1'b0;
    end else begin
      h0 <= {vsync, hsync, de};
      h1 <= h0;
      upd_e <= ~vsync & ~vprev;
      vprev <= ~vsync;
    end
  end

  always @(negedge pclk) begin
    if (mon_on) begin
      logic [24:0] e;
      check("o_vsync", o_vsync, h1[2]);
      check("o_hsync", o_hsync, h1[1]);
      check("o_de", o_de, h1[0]);
      check("o_cfg_upd", o_cfg_upd, upd_e);
      if (o_de) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("o_data", o_data, e[23:0]);
          check("o_in_roi", o_in_roi, e[24]);
        end
      end else check("in_roi_blank", o_in_roi, 0);
    end
  end

  task automatic step(bit vs, bit hs, bit de_i, int x, int y);
    logic [23:0] d;
    bit roi;
    d = 24'($urandom);
    if (de_i) begin
      if (pix_q.size() > 0) d = pix_q.pop_front();
      roi = shd.en && x >= int'(shd.xs) && x < int'(shd.xe) && y >= int'(shd.ys) && y < int'(shd.ye);
      exp_q.push_back({roi, roi ? model_px(d, shd) : d});
    end
    vsync = ~vs; hsync = ~hs; de = de_i; data = d;
    @(posedge pclk); #1;
  endtask

  task automatic line(int np, int y);
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    for (int x = 0; x < np; x++) step(0, 0, 1, x, y);
    repeat (3) step(0, 0, 0, 0, 0);
  endtask

  // chg >= 0 swaps the live inputs to nxt before that line
  task automatic run_frame(int nl, int np, int chg);
    shd = cur;
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      if (l == chg) cur = nxt;
      line(np, l);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_de"}, o_de, 0);
    check({tag, "_roi"}, o_in_roi, 0);
    check({tag, "_upd"}, o_cfg_upd, 0);
    check({tag, "_vs"}, o_vsync, 1);
    check({tag, "_hs"}, o_hsync, 1);
  endtask

  initial begin
    #1 arst = 1'b1;
    #2 check_reset_outputs("rst");
    mon_on = 1'b1;
    repeat (2) @(posedge pclk);
    #1 arst = 1'b0;

    // live config set, but nothing loaded yet: pass-through
    cur = mk_cfg(1, 0, 12'h005, 0, 4095, 0, 2047);
    line(8, 0);

    pix_q = {24'h0000B7, 24'hFFFFFF, 24'h000000};
    run_frame(2, 8, -1);

    cur.rnd = 1'b1;
    pix_q = {24'h0000B7, 24'h0000F7, 24'h0000FF, 24'h000010};
    run_frame(1, 8, -1);

    // ch0 trim 8, ch1 trim 15 (clamped), ch2 untouched
    cur.trim = 12'h0F8;
    pix_q = {24'h000080, 24'h12FF80, 24'hAB7F7F};
    run_frame(1, 8, -1);
    cur.rnd = 1'b0;
    pix_q = {24'h000080, 24'h12FF80};
    run_frame(1, 8, -1);

    cur = mk_cfg(1, 0, 12'h444, 4, 8, 0, 1);
    run_frame(3, 12, -1);

    cur = mk_cfg(1, 0, 12'h555, 0, 4095, 0, 2047);
    nxt = mk_cfg(1, 0, 12'h222, 0, 4095, 0, 2047);
    run_frame(4, 8, 2);
    run_frame(2, 8, -1);

    cur = mk_cfg(1, 1, 12'h333, 10, 10, 0, 2047);
    run_frame(2, 16, -1);

    repeat (6) begin
      cur = mk_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 12'($urandom),
                   $urandom_range(0, 12), $urandom_range(0, 16),
                   $urandom_range(0, 2), $urandom_range(0, 4));
      nxt = mk_cfg(1, $urandom_range(0, 1) == 1, 12'($urandom), 0, 4095, 0, 2047);
      run_frame($urandom_range(1, 4), $urandom_range(4, 20), $urandom_range(0, 4));
    end

    // reset in the middle of an active run
    cur = mk_cfg(1, 1, 12'h777, 0, 4095, 0, 2047);
    run_frame(1, 10, -1);
    repeat (2) step(0, 1, 0, 0, 0);
    for (int x = 0; x < 5; x++) step(0, 0, 1, x, 1);
    arst = 1'b1;
    exp_q.delete();
    shd = '0;
    vsync = 1'b1; hsync = 1'b1; de = 1'b0;
    #2 check_reset_outputs("mid_rst");
    @(posedge pclk); #1;
    arst = 1'b0;
    line(10, 0);
    run_frame(2, 10, -1);

    repeat (4) step(0, 0, 0, 0, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
